// File: rtl/full_st0_out_fifo.sv
// Frame-aware output FIFO downstream of full_st0: buffers {fst, data} words and pulses frame_done per drained frame.
// Optional framing check enabled by defining FULL_ST0_OUT_FIFO_FRAME_CHECK_EN (drives the sticky frame_err).
module full_st0_out_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_fst,
    input  logic                       in_vld,
    output logic                       in_rdy,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_fst,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       frame_done,
    output logic                       frame_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(FRAME_LEN + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [WIDTH:0]  mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    logic [0:0]      state_r;
    logic [0:0]      state_s;
    logic [BW-1:0]   beat_r;
    logic [BW-1:0]   beat_s;
    logic            done_s;
    logic            frame_done_r;

    // No bypass: a full buffer refuses input even while it is being popped.
    assign in_rdy   = (count_r != CW'(DEPTH));
    assign out_vld  = (count_r != CW'(0));
    assign push_s   = in_vld & in_rdy;
    assign pop_s    = out_vld & out_rdy;
    assign out_data = mem_r[rd_ptr_r][WIDTH-1:0];
    assign out_fst  = out_vld & mem_r[rd_ptr_r][WIDTH];
    assign count    = count_r;
    assign frame_done = frame_done_r;

    // Payload storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_fst, in_data};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Drain-side frame tracker next-state logic; advances only on pops.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        done_s  = 1'b0;
        if (pop_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (out_fst) begin
                        if (FRAME_LEN == 1) begin
                            done_s = 1'b1;
                            beat_s = BW'(0);
                        end else begin
                            state_s = ST_ACTIVE;
                            beat_s  = BW'(1);
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (out_fst) begin
                        beat_s = BW'(1);
                    end else if (beat_r == BW'(FRAME_LEN - 1)) begin
                        done_s  = 1'b1;
                        beat_s  = BW'(0);
                        state_s = ST_IDLE;
                    end else begin
                        beat_s = beat_r + BW'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    beat_s  = BW'(0);
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Tracker state and registered frame_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            beat_r       <= BW'(0);
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            beat_r       <= beat_s;
            frame_done_r <= done_s;
        end
    end

`ifdef FULL_ST0_OUT_FIFO_FRAME_CHECK_EN
    logic err_ev_s;
    logic frame_err_r;

    // Stray non-first word while idle, or a premature first word mid-frame.
    assign err_ev_s = pop_s & ((state_r == ST_IDLE) ? ~out_fst : out_fst);

    // Sticky framing error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_r <= 1'b0;
        end else if (err_ev_s) begin
            frame_err_r <= 1'b1;
        end else begin
            frame_err_r <= frame_err_r;
        end
    end

    assign frame_err = frame_err_r;
`else
    assign frame_err = 1'b0;
`endif

endmodule
